caxi4interconnect_cdc_wr_arb: RTL and testbench

Round-robin arbiter that shares the single write port of a clock-domain-crossing FIFO between up to eight requesters in the write clock domain. It picks one requester, forwards its beats into the FIFO write side (info valid/ready), and holds the grant until the requester's packet ends. The block sits directly upstream of the CDC write controller in the AXI4 interconnect convertors and uses the FIFO's `readyForInfo` as its only back-pressure source.

---
 rtl/caxi4interconnect_cdc_pkg.sv | 22 ++
 rtl/caxi4interconnect_rr_pick.sv | 39 +++
 rtl/caxi4interconnect_cdc_wr_arb.sv | 173 +++++++++++++++++
 tb/tb_caxi4interconnect_cdc_wr_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/caxi4interconnect_cdc_pkg.sv
// Shared definitions for the CDC write/read arbiters of the AXI4 interconnect.
// Holds the arbiter state encoding, the requester-count ceiling and a clog2
// helper used to validate index-width parameters at elaboration.
package caxi4interconnect_cdc_pkg;

  localparam int NUM_REQ_MAX = 8;

  // Arbiter state encoding; the state register doubles as the `locked` output.
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  // Ceiling log2, evaluated on parameters only.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/caxi4interconnect_rr_pick.sv
// Combinational round-robin search: first set bit of `req` at or after `start`,
// wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
// Ports: req (request vector), start (search origin), winner (index), any (some request).
module caxi4interconnect_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W:0]       sum;

  // Rotating a doubled copy puts the requester at `start` in bit 0.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[NUM_REQ-1:0] == '0 ? '0 : NUM_REQ'(req_dbl >> start);

  always_comb begin
    winner = '0;
    any    = 1'b0;
    sum    = '0;
    // Scan downward so the lowest rotated offset is the one that sticks.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sum = {1'b0, start} + (IDX_W + 1)'(k);
        if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
        winner = sum[IDX_W-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/caxi4interconnect_cdc_wr_arb.sv
// Round-robin arbiter sharing the CDC FIFO write port among NUM_REQ requesters;
// zero-latency request->infoIn and readyForInfo->reqReady, grant held per packet.
// Ports: reqValid/reqLast/reqData/reqReady (requesters), readyForInfo/infoInValid/
// infoIn (FIFO write side), grantIdx (owner or winner), locked (packet in progress).
// Optional macro CAXI4INTERCONNECT_CDC_WRARB_PKTLOCK_EN enables packet locking;
// without it every accepted beat is treated as last and arbitration runs per beat.
module caxi4interconnect_cdc_wr_arb
  import caxi4interconnect_cdc_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ-1:0]            reqLast,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]            reqReady,
  input  logic                          readyForInfo,
  output logic                          infoInValid,
  output logic [DATA_WIDTH-1:0]         infoIn,
  output logic [IDX_W-1:0]              grantIdx,
  output logic                          locked
);

  if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX || IDX_W != clog2(NUM_REQ)) begin : g_param_chk
    $error("caxi4interconnect_cdc_wr_arb: illegal NUM_REQ/IDX_W combination");
  end

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    if (p == IDX_W'(NUM_REQ - 1)) return '0;
    return p + IDX_W'(1);
  endfunction

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [IDX_W-1:0]      grant_int;
  logic                  vld_int;
  logic                  accept;
  logic                  grant_last;
  logic [DATA_WIDTH-1:0] mux_dat;

  caxi4interconnect_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (reqValid),
    .start  (rr_ptr_q),
    .winner (pick_idx),
    .any    (pick_any)
  );

  // Selects done by compare loops so an index never runs past NUM_REQ-1.
  always_comb begin
    mux_dat    = '0;
    grant_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_int == IDX_W'(i)) begin
        mux_dat    = reqData[i*DATA_WIDTH +: DATA_WIDTH];
        grant_last = reqLast[i];
      end
    end
  end

  assign accept = vld_int & readyForInfo;

`ifdef CAXI4INTERCONNECT_CDC_WRARB_PKTLOCK_EN
  logic             state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             owner_vld;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_int;
    end
  end

  // Next-state logic. Opening a packet does not move the pointer; closing it
  // advances past the owner (grant_int equals owner while locked).
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (grant_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = ptr_inc(grant_int);
      end else if (state_q == ST_IDLE) begin
        state_d = ST_LOCKED;
        owner_d = grant_int;
      end
    end
  end

  always_comb begin
    owner_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) owner_vld = reqValid[i];
    end
  end

  // Output logic: owner only while locked, search winner otherwise; with no
  // request the previous grant index is held.
  always_comb begin
    grant_int = grant_q;
    vld_int   = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant_int = owner_q;
      vld_int   = owner_vld;
    end else if (pick_any) begin
      grant_int = pick_idx;
      vld_int   = 1'b1;
    end
  end

  assign locked = (state_q == ST_LOCKED) & ~rst;
`else
  logic unused_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_int;
    end
  end

  // Every accepted beat closes its "packet", so the pointer moves per beat.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = ptr_inc(grant_int);
  end

  always_comb begin
    grant_int = grant_q;
    vld_int   = 1'b0;
    if (pick_any) begin
      grant_int = pick_idx;
      vld_int   = 1'b1;
    end
  end

  assign unused_last = ^reqLast ^ grant_last;
  assign locked      = 1'b0;
`endif

  // Ready decode; every output is forced low while reset is asserted.
  always_comb begin
    reqReady = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst && accept && grant_int == IDX_W'(i)) reqReady[i] = 1'b1;
    end
  end

  assign infoInValid = vld_int & ~rst;
  assign infoIn      = rst ? '0 : mux_dat;
  assign grantIdx    = rst ? '0 : grant_int;

endmodule

// File: tb/tb_caxi4interconnect_cdc_wr_arb.sv
module tb_caxi4interconnect_cdc_wr_arb;

`ifdef CAXI4INTERCONNECT_CDC_WRARB_PKTLOCK_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_last;
  logic [127:0] req_data;
  logic         ready;

  logic [3:0]  rdy4;  logic vld4; logic [31:0] info4; logic [1:0] gidx4; logic lock4;
  logic [2:0]  rdy3;  logic vld3; logic [31:0] info3; logic [1:0] gidx3; logic lock3;

  always #5 clk = ~clk;

  caxi4interconnect_cdc_wr_arb #(.NUM_REQ(4), .DATA_WIDTH(32), .IDX_W(2)) dut4 (
    .clk(clk), .rst(rst), .reqValid(req_valid), .reqLast(req_last), .reqData(req_data),
    .reqReady(rdy4), .readyForInfo(ready), .infoInValid(vld4), .infoIn(info4),
    .grantIdx(gidx4), .locked(lock4));

  caxi4interconnect_cdc_wr_arb #(.NUM_REQ(3), .DATA_WIDTH(32), .IDX_W(2)) dut3 (
    .clk(clk), .rst(rst), .reqValid(req_valid[2:0]), .reqLast(req_last[2:0]),
    .reqData(req_data[95:0]), .reqReady(rdy3), .readyForInfo(ready), .infoInValid(vld3),
    .infoIn(info3), .grantIdx(gidx3), .locked(lock3));

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: index 0 = 4-way, 1 = 3-way ----------------
  int m_ptr[2], m_owner[2], m_hold[2];
  bit m_locked[2];

  initial begin
    for (int s = 0; s < 2; s++) begin
      m_ptr[s] = 0; m_owner[s] = 0; m_hold[s] = 0; m_locked[s] = 0;
    end
  end

  task automatic model_eval(input int s, input int n, output int g, output bit v);
    bit any;
    int idx;
    any = 0;
    for (int k = 0; k < n; k++) if (req_valid[k]) any = 1;
    g = m_hold[s];
    v = 0;
    if (m_locked[s]) begin
      g = m_owner[s];
      v = req_valid[g];
    end else if (any) begin
      for (int k = n - 1; k >= 0; k--) begin
        idx = (m_ptr[s] + k) % n;
        if (req_valid[idx]) g = idx;
      end
      v = 1;
    end
  endtask

  initial begin
    int n, g, nptr, nown, nhold;
    bit v, acc, nlock;
    logic [3:0] a_rdy; logic a_vld, a_lock; logic [31:0] a_info; logic [1:0] a_g;
    string tag;
    int np[2], no[2], nh[2];
    bit nl[2];
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        n = (s == 0) ? 4 : 3;
        tag = (s == 0) ? "u4" : "u3";
        if (s == 0) begin
          a_rdy = rdy4; a_vld = vld4; a_info = info4; a_g = gidx4; a_lock = lock4;
        end else begin
          a_rdy = {1'b0, rdy3}; a_vld = vld3; a_info = info3; a_g = gidx3; a_lock = lock3;
        end
        if (rst) begin
          chk($sformatf("%s.rst_outputs", tag), {a_rdy, a_vld, a_lock, a_g, 24'd0} | a_info, 32'd0);
          nptr = 0; nown = 0; nhold = 0; nlock = 0;
        end else begin
          model_eval(s, n, g, v);
          acc = v && ready;
          chk($sformatf("%s.reqReady", tag), a_rdy, acc ? (32'd1 << g) : 32'd0);
          chk($sformatf("%s.infoInValid", tag), a_vld, v);
          chk($sformatf("%s.grantIdx", tag), a_g, g);
          chk($sformatf("%s.locked", tag), a_lock, m_locked[s]);
          if (v) chk($sformatf("%s.infoIn", tag), a_info, req_data[g*32 +: 32]);
          nptr = m_ptr[s]; nown = m_owner[s]; nlock = m_locked[s]; nhold = g;
          if (acc) begin
            if (!PKT || req_last[g]) begin
              nptr = (g + 1) % n; nlock = 0;
            end else if (!m_locked[s]) begin
              nlock = 1; nown = g;
            end
          end
        end
        np[s] = nptr; no[s] = nown; nh[s] = nhold; nl[s] = nlock;
      end
      @(posedge clk);
      for (int s = 0; s < 2; s++) begin
        m_ptr[s] = np[s]; m_owner[s] = no[s]; m_hold[s] = nh[s]; m_locked[s] = nl[s];
      end
    end
  end

  // ---------------- requester stimulus ----------------
  int plen[4], beat[4], left[4];

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) begin plen[i] = 1; beat[i] = 0; left[i] = 0; end
  endtask

  task automatic to_check();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = left[i] > 0;
      req_last[i]  = (beat[i] == plen[i] - 1);
      req_data[i*32 +: 32] = {8'(i), 24'(beat[i])};
    end
    @(negedge clk);
    #1;
  endtask

  task automatic finish_cycle();
    for (int i = 0; i < 4; i++) begin
      if (rdy4[i]) begin
        beat[i]++;
        if (beat[i] == plen[i]) begin beat[i] = 0; left[i]--; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int grot[5];
    int gp[4], gn[4], lp[4];
    logic [31:0] got[$];
    grot = '{0, 1, 2, 3, 0};
    gp = '{2, 2, 2, 0}; gn = '{2, 0, 2, 0}; lp = '{0, 1, 1, 0};
    rst = 1; ready = 1; req_valid = 0; req_last = 0; req_data = 0;
    clear_reqs();
    @(posedge clk); #1;

    // reset with requests present: outputs forced low
    for (int i = 0; i < 4; i++) left[i] = 1;
    to_check();
    chk("rst_vld", vld4, 0); chk("rst_rdy", rdy4, 0);
    chk("rst_gidx", gidx4, 0); chk("rst_lock", lock4, 0);
    finish_cycle();
    rst = 0;

    // basic rotation
    for (int i = 0; i < 4; i++) left[i] = 2;
    for (int c = 0; c < 5; c++) begin
      to_check();
      chk($sformatf("rot_grant%0d", c), gidx4, grot[c]);
      chk($sformatf("rot_rdy%0d", c), rdy4, 32'd1 << grot[c]);
      chk($sformatf("rot_info%0d", c), info4, {8'(grot[c]), 24'd0});
      finish_cycle();
    end
    clear_reqs(); to_check(); finish_cycle();

    // packet lock: requester 2 sends 3 beats, requester 0 always valid
    plen[2] = 3; left[2] = 1; left[0] = 4;
    for (int c = 0; c < 4; c++) begin
      to_check();
      chk($sformatf("lock_grant%0d", c), gidx4, PKT ? gp[c] : gn[c]);
      chk($sformatf("lock_locked%0d", c), lock4, PKT ? lp[c] : 0);
      finish_cycle();
    end
    clear_reqs(); to_check(); finish_cycle();

    // back-pressure mid-packet from requester 1, requester 3 competing
    plen[1] = 4; left[1] = 1; left[3] = 1;
    for (int c = 0; c < 24 && left[1] > 0; c++) begin
      ready = !(c >= 1 && c <= 5);
      to_check();
      if (c >= 1 && c <= 5) begin
        chk($sformatf("bp_rdy%0d", c), rdy4, 0);
        chk($sformatf("bp_vld%0d", c), vld4, 1);
        chk($sformatf("bp_grant%0d", c), gidx4, PKT ? 1 : 3);
      end
      if (rdy4[1]) got.push_back(info4);
      finish_cycle();
    end
    ready = 1;
    chk("bp_beat_count", got.size(), 4);
    for (int k = 0; k < got.size(); k++) chk($sformatf("bp_beat%0d", k), got[k], 32'h0100_0000 + k);
    clear_reqs(); to_check(); finish_cycle();

    // reset during beat 2 of a 4-beat packet from requester 1
    plen[1] = 4; left[1] = 1;
    to_check();
    chk("rstpkt_first_grant", gidx4, 1);
    finish_cycle();
    rst = 1;
    to_check();
    chk("rstpkt_rdy", rdy4, 0); chk("rstpkt_vld", vld4, 0); chk("rstpkt_info", info4, 0);
    chk("rstpkt_gidx", gidx4, 0); chk("rstpkt_lock", lock4, 0);
    finish_cycle();
    rst = 0;
    clear_reqs();
    left[1] = 1; left[3] = 1;
    to_check();
    chk("post_rst_grant", gidx4, 1);
    chk("post_rst_rdy", rdy4, 4'b0010);
    chk("post_rst_lock", lock4, 0);
    finish_cycle();
    clear_reqs();

    // wrap on the 3-way instance: grant 2, then 0 and 2 pending -> 0 wins
    left[2] = 1;
    to_check();
    chk("wrap3_grant2", gidx3, 2);
    finish_cycle();
    left[0] = 1; left[2] = 1;
    to_check();
    chk("wrap3_grant0", gidx3, 0);
    chk("wrap3_rdy", rdy3, 3'b001);
    finish_cycle();
    clear_reqs(); to_check(); finish_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
